fetch_pusher: RTL and testbench

- Producer end of the instruction-buffer interface: generates fetch PCs, requests instruction pairs from the ICache, and pushes them into the instruction buffer.
- Drives fetch_inst_1_en/fetch_inst_2_en together with their data and PC lanes.
- The buffer exposes no full flag, so this block tracks buffer occupancy with a credit counter. The counter is fed by the same send enables the issue stage gives the buffer.

---
 rtl/fetch_pusher.sv | 162 ++++++++++++++++
 tb/tb_fetch_pusher.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pusher.sv
// Fetch producer: requests ICache pairs, pushes them into the instruction buffer one cycle after the response.
// Buffer space is tracked with a credit counter; optional FETCH_PERF_CNT_EN adds push and credit-stall counters.
module fetch_pusher #(
  parameter logic [31:0] RESET_PC  = 32'h1c000000,
  parameter int          BUF_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        send_inst_1_en,
  input  logic        send_inst_2_en,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic        inst_rvalid,
  input  logic [31:0] inst_rdata_1,
  input  logic [31:0] inst_rdata_2,
  output logic [31:0] inst_1_o,
  output logic [31:0] inst_2_o,
  output logic [31:0] pc_1_o,
  output logic [31:0] pc_2_o,
  output logic        fetch_inst_1_en,
  output logic        fetch_inst_2_en
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_push_cnt,
  output logic [31:0] perf_credit_stall_cnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DROP = 2'd3;
  localparam logic [6:0] CAP  = 7'(BUF_DEPTH - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [5:0]  occ_q, occ_d;
  logic        en1_q, en1_d, en2_q, en2_d;
  logic [31:0] i1_q, i1_d, i2_q, i2_d, p1_q, p1_d, p2_q, p2_d;

  logic [5:0]  popped;
  logic [5:0]  occ_pop;
  logic [1:0]  n;
  logic [6:0]  occ_sum;
  logic        credit_ok;
  logic [1:0]  reserve;

  always_comb begin
    popped    = {5'b0, send_inst_1_en} + {5'b0, send_inst_2_en};
    occ_pop   = (occ_q >= popped) ? occ_q - popped : 6'd0;
    n         = pc_q[2] ? 2'd1 : 2'd2;
    occ_sum   = {1'b0, occ_pop} + {5'b0, n};
    credit_ok = (occ_sum <= CAP);
    reserve   = (state_q == REQ && inst_ack) ? n : 2'd0;

    state_d = state_q;
    pc_d    = pc_q;
    occ_d   = occ_pop + {4'b0, reserve};
    en1_d   = 1'b0;
    en2_d   = 1'b0;
    i1_d    = 32'd0;
    i2_d    = 32'd0;
    p1_d    = 32'd0;
    p2_d    = 32'd0;

    case (state_q)
      IDLE: if (credit_ok) state_d = REQ;
      REQ:  if (inst_ack) state_d = WAIT;
      WAIT: if (inst_rvalid) begin
        state_d = IDLE;
        pc_d    = pc_q + {28'b0, n, 2'b00};
        en1_d   = 1'b1;
        i1_d    = inst_rdata_1;
        p1_d    = pc_q;
        if (n == 2'd2) begin
          en2_d = 1'b1;
          i2_d  = inst_rdata_2;
          p2_d  = pc_q + 32'd4;
        end
      end
      default: if (inst_rvalid) state_d = IDLE;
    endcase

    // An acked request still has a response in flight, so it must be drained in DROP.
    if (flush) begin
      pc_d  = flush_pc;
      occ_d = 6'd0;
      en1_d = 1'b0;
      en2_d = 1'b0;
      i1_d  = 32'd0;
      i2_d  = 32'd0;
      p1_d  = 32'd0;
      p2_d  = 32'd0;
      case (state_q)
        IDLE:    state_d = IDLE;
        REQ:     state_d = inst_ack ? DROP : IDLE;
        default: state_d = inst_rvalid ? IDLE : DROP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      occ_q   <= 6'd0;
      en1_q   <= 1'b0;
      en2_q   <= 1'b0;
      i1_q    <= 32'd0;
      i2_q    <= 32'd0;
      p1_q    <= 32'd0;
      p2_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      occ_q   <= occ_d;
      en1_q   <= en1_d;
      en2_q   <= en2_d;
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
    end
  end

  assign inst_req        = (state_q == REQ);
  assign inst_addr       = inst_req ? pc_q : 32'd0;
  assign inst_1_o        = i1_q;
  assign inst_2_o        = i2_q;
  assign pc_1_o          = p1_q;
  assign pc_2_o          = p2_q;
  assign fetch_inst_1_en = en1_q;
  assign fetch_inst_2_en = en2_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] push_cnt_q, push_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    push_cnt_d  = push_cnt_q + {31'b0, en1_q} + {31'b0, en2_q};
    stall_cnt_d = stall_cnt_q;
    if (state_q == IDLE && !credit_ok && !flush) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      push_cnt_q  <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      push_cnt_q  <= push_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_push_cnt         = push_cnt_q;
  assign perf_credit_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pusher.sv
// Directed bench for fetch_pusher with a scoreboard of expected buffer pushes.
module tb_fetch_pusher;
  logic        clk = 1'b0;
  logic        rst, flush, send_inst_1_en, send_inst_2_en;
  logic [31:0] flush_pc;
  logic        inst_req, inst_ack, inst_rvalid;
  logic [31:0] inst_addr, inst_rdata_1, inst_rdata_2;
  logic [31:0] inst_1_o, inst_2_o, pc_1_o, pc_2_o;
  logic        fetch_inst_1_en, fetch_inst_2_en;

  always #5 clk = ~clk;

  fetch_pusher dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
    .send_inst_1_en(send_inst_1_en), .send_inst_2_en(send_inst_2_en),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack),
    .inst_rvalid(inst_rvalid), .inst_rdata_1(inst_rdata_1), .inst_rdata_2(inst_rdata_2),
    .inst_1_o(inst_1_o), .inst_2_o(inst_2_o), .pc_1_o(pc_1_o), .pc_2_o(pc_2_o),
    .fetch_inst_1_en(fetch_inst_1_en), .fetch_inst_2_en(fetch_inst_2_en)
  );

  typedef struct packed {
    logic        e1;
    logic        e2;
    logic [31:0] i1;
    logic [31:0] i2;
    logic [31:0] p1;
    logic [31:0] p2;
  } push_t;

  push_t       sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_pc;
  logic [5:0]  m_occ;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_no_push(input string tag);
    chk(tag, {30'b0, fetch_inst_1_en, fetch_inst_2_en}, 32'd0);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 64 && inst_req !== 1'b1; i++) tick();
    chk("req_seen", 32'(inst_req), 32'd1);
    chk("req_addr", inst_addr, m_pc);
  endtask

  task automatic fetch(input int hold, input int rv_dly, input logic [31:0] d1, input logic [31:0] d2);
    push_t e, g;
    int    n;
    wait_req();
    n = m_pc[2] ? 1 : 2;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_req", 32'(inst_req), 32'd1);
      chk("hold_addr", inst_addr, m_pc);
      chk("hold_occ", 32'(dut.occ_q), 32'(m_occ));
    end
    inst_ack = 1'b1;
    tick();
    inst_ack = 1'b0;
    m_occ = m_occ + 6'(n);
    chk("wait_req_low", 32'(inst_req), 32'd0);
    for (int i = 1; i < rv_dly; i++) begin
      tick();
      chk_no_push("wait_no_push");
    end
    inst_rvalid  = 1'b1;
    inst_rdata_1 = d1;
    inst_rdata_2 = d2;
    e.e1 = 1'b1;
    e.e2 = (n == 2);
    e.i1 = d1;
    e.p1 = m_pc;
    e.i2 = (n == 2) ? d2 : 32'd0;
    e.p2 = (n == 2) ? m_pc + 32'd4 : 32'd0;
    sb.push_back(e);
    m_pc = m_pc + 32'(4 * n);
    tick();
    inst_rvalid = 1'b0;
    g = {fetch_inst_1_en, fetch_inst_2_en, inst_1_o, inst_2_o, pc_1_o, pc_2_o};
    e = sb.pop_front();
    chk("push_en", {30'b0, g.e1, g.e2}, {30'b0, e.e1, e.e2});
    chk("push_inst1", g.i1, e.i1);
    chk("push_inst2", g.i2, e.i2);
    chk("push_pc1", g.p1, e.p1);
    chk("push_pc2", g.p2, e.p2);
    chk("push_occ", 32'(dut.occ_q), 32'(m_occ));
    tick();
    chk_no_push("push_one_cycle");
  endtask

  task automatic do_flush(input logic [31:0] fpc);
    flush    = 1'b1;
    flush_pc = fpc;
    tick();
    flush = 1'b0;
    m_pc  = fpc;
    m_occ = 6'd0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; flush_pc = 32'd0;
    send_inst_1_en = 1'b0; send_inst_2_en = 1'b0;
    inst_ack = 1'b0; inst_rvalid = 1'b0; inst_rdata_1 = 32'd0; inst_rdata_2 = 32'd0;
    tick(); tick();
    chk("rst_req", 32'(inst_req), 32'd0);
    chk("rst_addr", inst_addr, 32'd0);
    chk_no_push("rst_en");
    chk("rst_lanes", inst_1_o | inst_2_o | pc_1_o | pc_2_o, 32'd0);
    chk("rst_occ", 32'(dut.occ_q), 32'd0);
    chk("rst_pc", dut.pc_q, 32'h1c000000);
    rst   = 1'b1;
    m_pc  = 32'h1c000000;
    m_occ = 6'd0;

    // First pair right out of reset, then a redirect to an odd word.
    fetch(0, 2, 32'h11, 32'h22);
    do_flush(32'h1c000104);
    chk("flush_occ", 32'(dut.occ_q), 32'd0);
    chk("flush_req_low", 32'(inst_req), 32'd0);
    fetch(0, 2, 32'h33, 32'h44);
    fetch(0, 1, 32'h55, 32'h66);

    // Fill the credits with no sends: fetch must stop at 30.
    do_flush(32'h1c000200);
    for (int i = 0; i < 15; i++) fetch(0, 1, 32'(i), 32'(~i));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("credit_block", 32'(inst_req), 32'd0);
    end
    chk("occ_full", 32'(dut.occ_q), 32'd30);
    send_inst_1_en = 1'b1;
    tick();
    send_inst_1_en = 1'b0;
    m_occ = m_occ - 6'd1;
    chk("occ_pop1", 32'(dut.occ_q), 32'(m_occ));
    fetch(0, 1, 32'haaaa, 32'hbbbb);
    chk("credit_block31", 32'(inst_req), 32'd0);
    send_inst_1_en = 1'b1;
    send_inst_2_en = 1'b1;
    tick();
    send_inst_1_en = 1'b0;
    send_inst_2_en = 1'b0;
    m_occ = m_occ - 6'd2;
    chk("occ_pop2", 32'(dut.occ_q), 32'(m_occ));
    chk("resume_req", 32'(inst_req), 32'd1);

    // Flush a pending un-acked request.
    do_flush(32'h1c000400);
    chk("flush_req_drop", 32'(inst_req), 32'd0);
    chk("flush_req_occ", 32'(dut.occ_q), 32'd0);

    // Flush while waiting for the response: the response is dropped.
    wait_req();
    inst_ack = 1'b1;
    tick();
    inst_ack = 1'b0;
    do_flush(32'h1c000500);
    chk("wflush_occ", 32'(dut.occ_q), 32'd0);
    tick();
    chk("drop_no_req", 32'(inst_req), 32'd0);
    inst_rvalid = 1'b1; inst_rdata_1 = 32'hdead; inst_rdata_2 = 32'hbeef;
    tick();
    inst_rvalid = 1'b0;
    chk_no_push("drop_no_push");
    fetch(0, 2, 32'h77, 32'h88);

    // Flush in the same cycle as the response.
    wait_req();
    inst_ack = 1'b1;
    tick();
    inst_ack = 1'b0;
    tick();
    inst_rvalid = 1'b1;
    do_flush(32'h1c000600);
    inst_rvalid = 1'b0;
    chk_no_push("coinc_no_push");
    chk("coinc_req_low", 32'(inst_req), 32'd0);
    chk("coinc_occ", 32'(dut.occ_q), 32'd0);
    tick();
    chk("coinc_req", 32'(inst_req), 32'd1);
    chk("coinc_addr", inst_addr, 32'h1c000600);

    // Slow ack: request must stay stable.
    fetch(5, 2, 32'h99, 32'hcc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
